// File: rtl/cordic_vector_if.sv
// Request/result bundle for the vectoring CORDIC: operands and start in, angle/magnitude and status out.
interface cordic_vector_if;
    logic               start;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic signed [15:0] angle;
    logic signed [15:0] magnitude;
    logic               busy;
    logic               done;

    modport master (output start, x_in, y_in, input  angle, magnitude, busy, done);
    modport slave  (input  start, x_in, y_in, output angle, magnitude, busy, done);
endinterface

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: atan2(y,x) in Q3.13 and gain-compensated magnitude in Q2.14.
// One micro-rotation per clock, preceded by a quadrant pre-rotation and followed by a gain scale.
module cordic_vector #(
    parameter int unsigned ITERATIONS = 14
) (
    input logic        clock,
    input logic        reset,
    cordic_vector_if.slave cv
);

    localparam int unsigned XW     = 18;
    localparam int unsigned ZW     = 16;
    localparam int unsigned CW     = 4;
    localparam int unsigned PW     = 34;
    localparam int unsigned FRAC   = 14;
    localparam logic signed [ZW-1:0] HALF_PI = 16'sd12868;
    localparam logic signed [15:0]   K_INV   = 16'sd9949;
    localparam logic signed [PW-1:0] MAG_MAX = 34'sd32767;
    localparam logic [CW-1:0]        LAST_IT = CW'(ITERATIONS - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_SCALE, S_DONE} state_t;

    state_t                state_q;
    logic signed [XW-1:0]  x_q, y_q;
    logic signed [ZW-1:0]  z_q;
    logic [CW-1:0]         cnt_q;
    logic                  zero_q;
    logic signed [15:0]    mag_q;
    logic signed [15:0]    angle_q, magnitude_q;
    logic                  busy_q, done_q;

    logic signed [XW-1:0]  x_sh_c, y_sh_c;
    logic signed [ZW-1:0]  atan_c;
    logic signed [PW-1:0]  prod_c, scaled_c;
    logic signed [15:0]    mag_c;

    function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
        case (idx)
            4'd0:    return 16'sd6434;
            4'd1:    return 16'sd3798;
            4'd2:    return 16'sd2007;
            4'd3:    return 16'sd1019;
            4'd4:    return 16'sd511;
            4'd5:    return 16'sd256;
            4'd6:    return 16'sd128;
            4'd7:    return 16'sd64;
            4'd8:    return 16'sd32;
            4'd9:    return 16'sd16;
            4'd10:   return 16'sd8;
            4'd11:   return 16'sd4;
            4'd12:   return 16'sd2;
            4'd13:   return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    // Shifted operands for the current micro-rotation and the saturating gain scale.
    always_comb begin
        x_sh_c   = x_q >>> cnt_q;
        y_sh_c   = y_q >>> cnt_q;
        atan_c   = atan_lut(cnt_q);
        prod_c   = PW'(x_q) * PW'(K_INV);
        scaled_c = prod_c >>> FRAC;
        mag_c    = 16'sd0;
        if (scaled_c > MAG_MAX) begin
            mag_c = 16'sd32767;
        end else if (!scaled_c[PW-1]) begin
            mag_c = 16'(scaled_c);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            mag_q       <= '0;
            angle_q     <= '0;
            magnitude_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cv.start) begin
                        x_q     <= XW'(cv.x_in);
                        y_q     <= XW'(cv.y_in);
                        zero_q  <= (cv.x_in == 16'sd0) && (cv.y_in == 16'sd0);
                        busy_q  <= 1'b1;
                        state_q <= S_PRE;
                    end
                end
                // Fold left half-plane into the right half-plane by +/-90 degrees.
                S_PRE: begin
                    cnt_q <= '0;
                    if (x_q[XW-1]) begin
                        if (!y_q[XW-1]) begin
                            x_q <= y_q;
                            y_q <= -x_q;
                            z_q <= HALF_PI;
                        end else begin
                            x_q <= -y_q;
                            y_q <= x_q;
                            z_q <= -HALF_PI;
                        end
                    end else begin
                        z_q <= '0;
                    end
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    if (!y_q[XW-1]) begin
                        x_q <= x_q + y_sh_c;
                        y_q <= y_q - x_sh_c;
                        z_q <= z_q + atan_c;
                    end else begin
                        x_q <= x_q - y_sh_c;
                        y_q <= y_q + x_sh_c;
                        z_q <= z_q - atan_c;
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_IT) begin
                        state_q <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    mag_q   <= mag_c;
                    state_q <= S_DONE;
                end
                // Zero vector has no defined angle; report 0 rather than the accumulated table sum.
                S_DONE: begin
                    angle_q     <= zero_q ? 16'sd0 : z_q;
                    magnitude_q <= mag_q;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cv.angle     = angle_q;
    assign cv.magnitude = magnitude_q;
    assign cv.busy      = busy_q;
    assign cv.done      = done_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: a real-valued atan2/hypot model queues expectations at accept,
// a done monitor pops and compares angle, magnitude and latency.
module tb_cordic_vector;

    localparam int ITERATIONS = 14;
    localparam int LATENCY    = ITERATIONS + 3;
    localparam int PI_Q13     = 25736;

    typedef struct {
        int ang;
        int mag;
        int ta;
        int tm;
        int n;
    } exp_t;

    logic clock;
    logic reset;
    cordic_vector_if cv ();

    cordic_vector #(.ITERATIONS(ITERATIONS)) dut (
        .clock (clock),
        .reset (reset),
        .cv    (cv.slave)
    );

    exp_t sb[$];
    int   cyc;
    int   passed;
    int   total;
    int   last_mag;
    int   last_ang;
    int   last_tm;
    int   last_ta;
    logic prev_done;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp, input int tol);
        int d;
        total++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d <= tol) passed++;
        else $display("FAIL %s: got %0d want %0d (+/-%0d)", tag, obs, exp, tol);
    endtask

    function automatic void model(input int x, input int y, output int a, output int m);
        real r;
        if (x == 0 && y == 0) begin
            a = 0;
            m = 0;
        end else begin
            a = int'($atan2(real'(y), real'(x)) * 8192.0);
            r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
            m = (r > 32767.0) ? 32767 : int'(r);
        end
    endfunction

    // Done monitor: pops one expectation per done pulse.
    always @(negedge clock) begin
        if (reset && cv.done) begin
            if (prev_done) check_val("done_pulse_width", 1, 0, 0);
            if (sb.size() == 0) begin
                check_val("spurious_done", 1, 0, 0);
            end else begin
                exp_t e;
                int   a;
                e = sb.pop_front();
                a = int'($signed(cv.angle));
                if (a - e.ang > PI_Q13) a -= 2 * PI_Q13;
                else if (e.ang - a > PI_Q13) a += 2 * PI_Q13;
                check_val("angle", a, e.ang, e.ta);
                check_val("magnitude", int'($signed(cv.magnitude)), e.mag, e.tm);
                check_val("latency", cyc - e.n, LATENCY, 0);
                check_val("busy_at_done", int'(cv.busy), 0, 0);
            end
        end
        prev_done = cv.done;
    end

    // Drive one conversion; optionally release reset in the same cycle or poke start mid-flight.
    task automatic convert(input int x, input int y, input int ta, input int tm,
                           input bit rel, input bit poke, input bit wait_done);
        exp_t e;
        bit   got;
        @(negedge clock);
        if (rel) reset = 1'b1;
        cv.start = 1'b1;
        cv.x_in  = 16'(x);
        cv.y_in  = 16'(y);
        @(posedge clock);
        #1;
        model(x, y, e.ang, e.mag);
        e.ta = ta;
        e.tm = tm;
        e.n  = cyc;
        sb.push_back(e);
        last_ang = e.ang;
        last_mag = e.mag;
        last_ta  = ta;
        last_tm  = tm;
        @(negedge clock);
        cv.start = 1'b0;
        cv.x_in  = 16'sd1234;
        cv.y_in  = -16'sd4321;
        check_val("busy_after_accept", int'(cv.busy), 1, 0);
        if (poke) begin
            repeat (4) @(negedge clock);
            cv.start = 1'b1;
            cv.x_in  = -16'sd9000;
            cv.y_in  = 16'sd5000;
            @(negedge clock);
            cv.start = 1'b0;
        end
        if (wait_done) begin
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clock);
                #1;
                if (sb.size() == 0) got = 1'b1;
            end
            if (!got) begin
                check_val("done_timeout", 0, 1, 0);
                sb.delete();
            end
            repeat (3) @(negedge clock);
            check_val("hold_magnitude", int'($signed(cv.magnitude)), last_mag, last_tm);
            check_val("hold_angle", int'($signed(cv.angle)), last_ang, last_ta);
            check_val("idle_done_low", int'(cv.done), 0, 0);
        end
    endtask

    initial begin
        int x, y;
        cyc       = 0;
        passed    = 0;
        total     = 0;
        prev_done = 1'b0;
        cv.start  = 1'b0;
        cv.x_in   = '0;
        cv.y_in   = '0;
        reset     = 1'b1;
        #2 reset  = 1'b0;
        #1;
        check_val("reset_angle", int'($signed(cv.angle)), 0, 0);
        check_val("reset_magnitude", int'($signed(cv.magnitude)), 0, 0);
        check_val("reset_busy", int'(cv.busy), 0, 0);
        check_val("reset_done", int'(cv.done), 0, 0);
        repeat (2) @(negedge clock);

        // First start presented together with reset release.
        convert(16384, 0, 2, 8, 1'b1, 1'b0, 1'b1);
        convert(11585, 11585, 4, 8, 1'b0, 1'b0, 1'b1);
        convert(0, 16384, 4, 8, 1'b0, 1'b0, 1'b1);
        convert(-16384, 0, 4, 8, 1'b0, 1'b0, 1'b1);
        convert(-11585, -11585, 4, 8, 1'b0, 1'b0, 1'b1);
        convert(0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        convert(-32768, -32768, 4, 0, 1'b0, 1'b0, 1'b1);
        convert(3000, -15000, 12, 12, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            do begin
                x = int'($urandom_range(60000, 0)) - 30000;
                y = int'($urandom_range(60000, 0)) - 30000;
            end while (((x < 0) ? -x : x) + ((y < 0) ? -y : y) < 12000);
            convert(x, y, 12, 12, 1'b0, 1'b0, 1'b1);
        end

        // Abort a conversion at cycle 8, then restart on the first edge after release.
        convert(-7000, 9000, 12, 12, 1'b0, 1'b0, 1'b0);
        repeat (7) @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("abort_angle", int'($signed(cv.angle)), 0, 0);
        check_val("abort_magnitude", int'($signed(cv.magnitude)), 0, 0);
        check_val("abort_busy", int'(cv.busy), 0, 0);
        check_val("abort_done", int'(cv.done), 0, 0);
        sb.delete();
        repeat (2) @(negedge clock);
        convert(5000, 14000, 12, 12, 1'b1, 1'b0, 1'b1);
        repeat (25) @(negedge clock);
        check_val("scoreboard_empty", sb.size(), 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
